// File: rtl/axi_ram_pkg.sv
// Shared definitions for the AXI RAM wrapper front ends (read and write
// interfaces): AXI burst/response encodings and the common FSM state type.
package axi_ram_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } axi_ram_state_e;

endpackage

// File: rtl/axi_ram_wr_if.sv
// AXI4 slave write-channel front end for the on-chip AXI RAM.
// Accepts one AW burst at a time, turns each W beat into a registered RAM
// write command (addr/data/strb/last + AW attributes) under a valid/ready
// handshake, and passes RAM write completions straight through to B.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   s_axi_aw*           AXI write address channel (slave side)
//   s_axi_w*            AXI write data channel (wlast is not used)
//   s_axi_b*            AXI write response channel (pass-through)
//   ram_wr_cmd_*        per-beat RAM write command, en/ready handshake
//   ram_wr_resp_*       RAM write completion, valid/ready handshake
module axi_ram_wr_if
    import axi_ram_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 16,
    parameter int STRB_WIDTH    = DATA_WIDTH / 8,
    parameter int ID_WIDTH      = 8,
    parameter bit AWUSER_ENABLE = 1'b0,
    parameter int AWUSER_WIDTH  = 1,
    parameter int BUSER_WIDTH   = 1
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awlock,
    input  logic [3:0]              s_axi_awcache,
    input  logic [2:0]              s_axi_awprot,
    input  logic [3:0]              s_axi_awqos,
    input  logic [3:0]              s_axi_awregion,
    input  logic [AWUSER_WIDTH-1:0] s_axi_awuser,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,

    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [STRB_WIDTH-1:0]   s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,

    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic [BUSER_WIDTH-1:0]  s_axi_buser,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,

    output logic [ID_WIDTH-1:0]     ram_wr_cmd_id,
    output logic [ADDR_WIDTH-1:0]   ram_wr_cmd_addr,
    output logic [DATA_WIDTH-1:0]   ram_wr_cmd_data,
    output logic [STRB_WIDTH-1:0]   ram_wr_cmd_strb,
    output logic                    ram_wr_cmd_lock,
    output logic [3:0]              ram_wr_cmd_cache,
    output logic [2:0]              ram_wr_cmd_prot,
    output logic [3:0]              ram_wr_cmd_qos,
    output logic [3:0]              ram_wr_cmd_region,
    output logic [AWUSER_WIDTH-1:0] ram_wr_cmd_auser,
    output logic                    ram_wr_cmd_en,
    output logic                    ram_wr_cmd_last,
    input  logic                    ram_wr_cmd_ready,

    input  logic [ID_WIDTH-1:0]     ram_wr_resp_id,
    input  logic [BUSER_WIDTH-1:0]  ram_wr_resp_user,
    input  logic                    ram_wr_resp_valid,
    output logic                    ram_wr_resp_ready
);

    localparam int unsigned SIZE_MAX = $clog2(STRB_WIDTH);

    // Elaboration-time parameter sanity
    if (STRB_WIDTH * 8 != DATA_WIDTH) begin : g_chk_strb_width
        $error("axi_ram_wr_if: STRB_WIDTH*8 must equal DATA_WIDTH");
    end
    if ((STRB_WIDTH & (STRB_WIDTH - 1)) != 0) begin : g_chk_strb_pow2
        $error("axi_ram_wr_if: STRB_WIDTH must be a power of two");
    end

    // wlast is intentionally ignored: framing comes from awlen alone
    logic unused_wlast;
    assign unused_wlast = s_axi_wlast;

    axi_ram_state_e          state_q, state_d;
    logic                    awready_q, awready_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    lock_q, lock_d;
    logic [3:0]              cache_q, cache_d;
    logic [2:0]              prot_q, prot_d;
    logic [3:0]              qos_q, qos_d;
    logic [3:0]              region_q, region_d;
    logic [AWUSER_WIDTH-1:0] user_q, user_d;
    logic [7:0]              count_q, count_d;
    logic [2:0]              size_q, size_d;
    logic [1:0]              burst_q, burst_d;

    logic [ID_WIDTH-1:0]     cmd_id_q, cmd_id_d;
    logic [ADDR_WIDTH-1:0]   cmd_addr_q, cmd_addr_d;
    logic [DATA_WIDTH-1:0]   cmd_data_q, cmd_data_d;
    logic [STRB_WIDTH-1:0]   cmd_strb_q, cmd_strb_d;
    logic                    cmd_lock_q, cmd_lock_d;
    logic [3:0]              cmd_cache_q, cmd_cache_d;
    logic [2:0]              cmd_prot_q, cmd_prot_d;
    logic [3:0]              cmd_qos_q, cmd_qos_d;
    logic [3:0]              cmd_region_q, cmd_region_d;
    logic [AWUSER_WIDTH-1:0] cmd_auser_q, cmd_auser_d;
    logic                    cmd_en_q, cmd_en_d;
    logic                    cmd_last_q, cmd_last_d;

    logic                    wready_c;
    logic                    aw_hs_c;
    logic                    w_hs_c;

    // W is accepted only in BURST and only when the cmd register is free
    // or being drained this cycle
    assign wready_c = (state_q == ST_BURST) && (!cmd_en_q || ram_wr_cmd_ready);
    assign aw_hs_c  = s_axi_awvalid && awready_q;
    assign w_hs_c   = s_axi_wvalid && wready_c;

    // Next-state and datapath
    always_comb begin
        state_d      = state_q;
        awready_d    = awready_q;
        id_d         = id_q;
        addr_d       = addr_q;
        lock_d       = lock_q;
        cache_d      = cache_q;
        prot_d       = prot_q;
        qos_d        = qos_q;
        region_d     = region_q;
        user_d       = user_q;
        count_d      = count_q;
        size_d       = size_q;
        burst_d      = burst_q;
        cmd_id_d     = cmd_id_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_data_d   = cmd_data_q;
        cmd_strb_d   = cmd_strb_q;
        cmd_lock_d   = cmd_lock_q;
        cmd_cache_d  = cmd_cache_q;
        cmd_prot_d   = cmd_prot_q;
        cmd_qos_d    = cmd_qos_q;
        cmd_region_d = cmd_region_q;
        cmd_auser_d  = cmd_auser_q;
        cmd_en_d     = cmd_en_q && !ram_wr_cmd_ready;
        cmd_last_d   = cmd_last_q;

        case (state_q)
            ST_IDLE: begin
                awready_d = 1'b1;
                if (aw_hs_c) begin
                    id_d      = s_axi_awid;
                    addr_d    = s_axi_awaddr;
                    lock_d    = s_axi_awlock;
                    cache_d   = s_axi_awcache;
                    prot_d    = s_axi_awprot;
                    qos_d     = s_axi_awqos;
                    region_d  = s_axi_awregion;
                    user_d    = s_axi_awuser;
                    count_d   = s_axi_awlen;
                    // Beats wider than the bus are clamped to the bus width
                    size_d    = (s_axi_awsize > 3'(SIZE_MAX)) ? 3'(SIZE_MAX) : s_axi_awsize;
                    burst_d   = s_axi_awburst;
                    awready_d = 1'b0;
                    state_d   = ST_BURST;
                end
            end
            ST_BURST: begin
                if (w_hs_c) begin
                    cmd_id_d     = id_q;
                    cmd_addr_d   = addr_q;
                    cmd_data_d   = s_axi_wdata;
                    cmd_strb_d   = s_axi_wstrb;
                    cmd_lock_d   = lock_q;
                    cmd_cache_d  = cache_q;
                    cmd_prot_d   = prot_q;
                    cmd_qos_d    = qos_q;
                    cmd_region_d = region_q;
                    cmd_auser_d  = AWUSER_ENABLE ? user_q : '0;
                    cmd_en_d     = 1'b1;
                    cmd_last_d   = (count_q == 8'd0);
                    // WRAP is handled as INCR
                    if (burst_q != BURST_FIXED) begin
                        addr_d = addr_q + (ADDR_WIDTH'(1) << size_q);
                    end
                    count_d = count_q - 8'd1;
                    if (count_q == 8'd0) begin
                        awready_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and cmd registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            awready_q    <= 1'b0;
            id_q         <= '0;
            addr_q       <= '0;
            lock_q       <= 1'b0;
            cache_q      <= '0;
            prot_q       <= '0;
            qos_q        <= '0;
            region_q     <= '0;
            user_q       <= '0;
            count_q      <= '0;
            size_q       <= '0;
            burst_q      <= '0;
            cmd_id_q     <= '0;
            cmd_addr_q   <= '0;
            cmd_data_q   <= '0;
            cmd_strb_q   <= '0;
            cmd_lock_q   <= 1'b0;
            cmd_cache_q  <= '0;
            cmd_prot_q   <= '0;
            cmd_qos_q    <= '0;
            cmd_region_q <= '0;
            cmd_auser_q  <= '0;
            cmd_en_q     <= 1'b0;
            cmd_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            awready_q    <= awready_d;
            id_q         <= id_d;
            addr_q       <= addr_d;
            lock_q       <= lock_d;
            cache_q      <= cache_d;
            prot_q       <= prot_d;
            qos_q        <= qos_d;
            region_q     <= region_d;
            user_q       <= user_d;
            count_q      <= count_d;
            size_q       <= size_d;
            burst_q      <= burst_d;
            cmd_id_q     <= cmd_id_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_data_q   <= cmd_data_d;
            cmd_strb_q   <= cmd_strb_d;
            cmd_lock_q   <= cmd_lock_d;
            cmd_cache_q  <= cmd_cache_d;
            cmd_prot_q   <= cmd_prot_d;
            cmd_qos_q    <= cmd_qos_d;
            cmd_region_q <= cmd_region_d;
            cmd_auser_q  <= cmd_auser_d;
            cmd_en_q     <= cmd_en_d;
            cmd_last_q   <= cmd_last_d;
        end
    end

    assign s_axi_awready     = awready_q;
    assign s_axi_wready      = wready_c;

    assign ram_wr_cmd_id     = cmd_id_q;
    assign ram_wr_cmd_addr   = cmd_addr_q;
    assign ram_wr_cmd_data   = cmd_data_q;
    assign ram_wr_cmd_strb   = cmd_strb_q;
    assign ram_wr_cmd_lock   = cmd_lock_q;
    assign ram_wr_cmd_cache  = cmd_cache_q;
    assign ram_wr_cmd_prot   = cmd_prot_q;
    assign ram_wr_cmd_qos    = cmd_qos_q;
    assign ram_wr_cmd_region = cmd_region_q;
    assign ram_wr_cmd_auser  = cmd_auser_q;
    assign ram_wr_cmd_en     = cmd_en_q;
    assign ram_wr_cmd_last   = cmd_last_q;

    // B channel is a straight pass-through of RAM completions
    assign s_axi_bvalid      = ram_wr_resp_valid;
    assign s_axi_bid         = ram_wr_resp_id;
    assign s_axi_buser       = ram_wr_resp_user;
    assign s_axi_bresp       = RESP_OKAY;
    assign ram_wr_resp_ready = s_axi_bready;

endmodule

// File: tb/tb_axi_ram_wr_if.sv
// Scoreboard bench for axi_ram_wr_if: bursts push expected RAM commands
// computed from the AXI address rules; a monitor pops and compares on every
// cmd handshake and checks payload stability while the RAM stalls.
module tb_axi_ram_wr_if;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int SW = 4;
    localparam int IW = 8;
    localparam int TIMEOUT = 400;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic          last;
        logic [15:0]   attr;
    } cmd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [IW-1:0] s_axi_awid = '0;
    logic [AW-1:0] s_axi_awaddr = '0;
    logic [7:0]    s_axi_awlen = '0;
    logic [2:0]    s_axi_awsize = '0;
    logic [1:0]    s_axi_awburst = '0;
    logic          s_axi_awlock = 1'b0;
    logic [3:0]    s_axi_awcache = '0;
    logic [2:0]    s_axi_awprot = '0;
    logic [3:0]    s_axi_awqos = '0;
    logic [3:0]    s_axi_awregion = '0;
    logic [0:0]    s_axi_awuser = '0;
    logic          s_axi_awvalid = 1'b0;
    logic          s_axi_awready;
    logic [DW-1:0] s_axi_wdata = '0;
    logic [SW-1:0] s_axi_wstrb = '0;
    logic          s_axi_wlast = 1'b0;
    logic          s_axi_wvalid = 1'b0;
    logic          s_axi_wready;
    logic [IW-1:0] s_axi_bid;
    logic [1:0]    s_axi_bresp;
    logic [0:0]    s_axi_buser;
    logic          s_axi_bvalid;
    logic          s_axi_bready = 1'b0;
    logic [IW-1:0] ram_wr_cmd_id;
    logic [AW-1:0] ram_wr_cmd_addr;
    logic [DW-1:0] ram_wr_cmd_data;
    logic [SW-1:0] ram_wr_cmd_strb;
    logic          ram_wr_cmd_lock;
    logic [3:0]    ram_wr_cmd_cache;
    logic [2:0]    ram_wr_cmd_prot;
    logic [3:0]    ram_wr_cmd_qos;
    logic [3:0]    ram_wr_cmd_region;
    logic [0:0]    ram_wr_cmd_auser;
    logic          ram_wr_cmd_en;
    logic          ram_wr_cmd_last;
    logic          ram_wr_cmd_ready = 1'b1;
    logic [IW-1:0] ram_wr_resp_id = '0;
    logic [0:0]    ram_wr_resp_user = '0;
    logic          ram_wr_resp_valid = 1'b0;
    logic          ram_wr_resp_ready;

    axi_ram_wr_if dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
        .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
        .s_axi_awregion(s_axi_awregion), .s_axi_awuser(s_axi_awuser),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_buser(s_axi_buser),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .ram_wr_cmd_id(ram_wr_cmd_id), .ram_wr_cmd_addr(ram_wr_cmd_addr),
        .ram_wr_cmd_data(ram_wr_cmd_data), .ram_wr_cmd_strb(ram_wr_cmd_strb),
        .ram_wr_cmd_lock(ram_wr_cmd_lock), .ram_wr_cmd_cache(ram_wr_cmd_cache),
        .ram_wr_cmd_prot(ram_wr_cmd_prot), .ram_wr_cmd_qos(ram_wr_cmd_qos),
        .ram_wr_cmd_region(ram_wr_cmd_region), .ram_wr_cmd_auser(ram_wr_cmd_auser),
        .ram_wr_cmd_en(ram_wr_cmd_en), .ram_wr_cmd_last(ram_wr_cmd_last),
        .ram_wr_cmd_ready(ram_wr_cmd_ready),
        .ram_wr_resp_id(ram_wr_resp_id), .ram_wr_resp_user(ram_wr_resp_user),
        .ram_wr_resp_valid(ram_wr_resp_valid), .ram_wr_resp_ready(ram_wr_resp_ready)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   cmd_count = 0;
    int   rdy_mode = 0;   // 0: ready high, 1: random, 2: driven by test
    cmd_t exp_q[$];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic logic [15:0] cur_attr();
        return {ram_wr_cmd_lock, ram_wr_cmd_cache, ram_wr_cmd_prot, ram_wr_cmd_qos, ram_wr_cmd_region};
    endfunction

    // RAM ready generator
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) ram_wr_cmd_ready = 1'b1;
            else if (rdy_mode == 1) ram_wr_cmd_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compare each accepted cmd and payload stability across stalls
    initial begin
        cmd_t e;
        cmd_t held;
        logic stalled;
        stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    chk("stall_en_held", 64'(ram_wr_cmd_en), 64'd1);
                    chk("stall_addr", 64'(ram_wr_cmd_addr), 64'(held.addr));
                    chk("stall_data", 64'(ram_wr_cmd_data), 64'(held.data));
                    chk("stall_strb_last", 64'({ram_wr_cmd_strb, ram_wr_cmd_last}),
                        64'({held.strb, held.last}));
                end
                if (ram_wr_cmd_en && !ram_wr_cmd_ready) begin
                    chk("stall_wready", 64'(s_axi_wready), 64'd0);
                    stalled = 1'b1;
                    held = '{id: ram_wr_cmd_id, addr: ram_wr_cmd_addr, data: ram_wr_cmd_data,
                             strb: ram_wr_cmd_strb, last: ram_wr_cmd_last, attr: cur_attr()};
                end else begin
                    stalled = 1'b0;
                end
                if (ram_wr_cmd_en && ram_wr_cmd_ready) begin
                    cmd_count++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_cmd_addr", 64'(ram_wr_cmd_addr), 64'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("cmd_addr", 64'(ram_wr_cmd_addr), 64'(e.addr));
                        chk("cmd_data", 64'(ram_wr_cmd_data), 64'(e.data));
                        chk("cmd_strb", 64'(ram_wr_cmd_strb), 64'(e.strb));
                        chk("cmd_last", 64'(ram_wr_cmd_last), 64'(e.last));
                        chk("cmd_id", 64'(ram_wr_cmd_id), 64'(e.id));
                        chk("cmd_attr", 64'(cur_attr()), 64'(e.attr));
                        chk("cmd_auser", 64'(ram_wr_cmd_auser), 64'd0);
                    end
                end
            end
        end
    end

    // One AW burst plus its W beats; abort_after >= 0 sends only that many beats
    task automatic run_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                             input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [DW-1:0] d0,
                             input logic [SW-1:0] s0, input bit gaps, input bit chk_tput,
                             input int abort_after);
        int         step;
        int         nbeats;
        int         n;
        logic [15:0] attr;
        logic [DW-1:0] wd[$];
        logic [SW-1:0] ws[$];
        cmd_t e;
        step   = 1 << ((size > 3'd2) ? 2 : int'(size));
        nbeats = (abort_after >= 0) ? abort_after : int'(len) + 1;
        attr   = 16'($urandom);
        for (int i = 0; i <= int'(len); i++) begin
            wd.push_back((i == 0) ? d0 : DW'($urandom));
            ws.push_back((i == 0) ? s0 : SW'($urandom));
        end
        for (int i = 0; i < nbeats; i++) begin
            e.id   = id;
            e.addr = (burst == 2'b00) ? addr : AW'(int'(addr) + i * step);
            e.data = wd[i];
            e.strb = ws[i];
            e.last = (i == int'(len));
            e.attr = attr;
            exp_q.push_back(e);
        end

        @(posedge clk);
        #1;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awsize = size;
        s_axi_awburst = burst;
        {s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awregion} = attr;
        s_axi_awuser = 1'($urandom);
        s_axi_awvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_axi_awready && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        chk("awready_wait", 64'(s_axi_awready), 64'd1);
        @(posedge clk);
        #1;
        s_axi_awvalid = 1'b0;
        chk("awready_low_in_burst", 64'(s_axi_awready), 64'd0);

        for (int i = 0; i < nbeats; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            s_axi_wvalid = 1'b1;
            s_axi_wdata  = wd[i];
            s_axi_wstrb  = ws[i];
            s_axi_wlast  = 1'($urandom);   // must not affect framing
            n = 0;
            @(negedge clk);
            while (!s_axi_wready && n < TIMEOUT) begin
                @(negedge clk);
                n++;
            end
            chk("wready_wait", 64'(s_axi_wready), 64'd1);
            if (chk_tput) chk("beat_per_cycle", 64'(n), 64'd0);
            @(posedge clk);
            #1;
            s_axi_wvalid = 1'b0;
            if (i == int'(len)) begin
                chk("awready_after_last", 64'(s_axi_awready), 64'd1);
                chk("wready_after_last", 64'(s_axi_wready), 64'd0);
            end
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < TIMEOUT) begin
            @(posedge clk);
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int base;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", 64'(s_axi_awready), 64'd0);
        chk("rst_wready", 64'(s_axi_wready), 64'd0);
        chk("rst_cmd_en", 64'(ram_wr_cmd_en), 64'd0);
        chk("rst_cmd_last", 64'(ram_wr_cmd_last), 64'd0);
        chk("rst_cmd_payload", 64'({ram_wr_cmd_addr, ram_wr_cmd_data, ram_wr_cmd_id}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("awready_first_cycle", 64'(s_axi_awready), 64'd0);
        @(posedge clk);
        #1;
        chk("awready_rises", 64'(s_axi_awready), 64'd1);

        // Single beat
        run_burst(8'd5, 16'h0010, 8'd0, 3'd2, 2'b01, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1, -1);
        drain("drain_single");

        // B pass-through: directed then random
        @(posedge clk);
        #1;
        ram_wr_resp_valid = 1'b1; ram_wr_resp_id = 8'd5; ram_wr_resp_user = 1'b0; s_axi_bready = 1'b1;
        @(negedge clk);
        chk("b_valid", 64'(s_axi_bvalid), 64'd1);
        chk("b_id", 64'(s_axi_bid), 64'd5);
        chk("b_resp", 64'(s_axi_bresp), 64'd0);
        chk("b_resp_ready", 64'(ram_wr_resp_ready), 64'd1);
        for (int i = 0; i < 8; i++) begin
            logic       v, r, u;
            logic [7:0] bid;
            v = 1'($urandom); r = 1'($urandom); u = 1'($urandom); bid = 8'($urandom);
            @(posedge clk);
            #1;
            ram_wr_resp_valid = v; s_axi_bready = r; ram_wr_resp_user = u; ram_wr_resp_id = bid;
            @(negedge clk);
            chk("b_rand_valid", 64'(s_axi_bvalid), 64'(v));
            chk("b_rand_ready", 64'(ram_wr_resp_ready), 64'(r));
            chk("b_rand_id_user", 64'({s_axi_bid, s_axi_buser}), 64'({bid, u}));
            chk("b_rand_resp", 64'(s_axi_bresp), 64'd0);
        end
        @(posedge clk);
        #1;
        ram_wr_resp_valid = 1'b0; s_axi_bready = 1'b0;

        // INCR len 3 at full rate, FIXED, narrow and oversize sizes
        run_burst(8'd1, 16'h0100, 8'd3, 3'd2, 2'b01, 32'h1111_0000, 4'h3, 1'b0, 1'b1, -1);
        drain("drain_incr");
        run_burst(8'd2, 16'h0040, 8'd2, 3'd2, 2'b00, 32'h2222_0000, 4'hC, 1'b0, 1'b1, -1);
        drain("drain_fixed");
        run_burst(8'd3, 16'h0003, 8'd1, 3'd0, 2'b01, 32'h3333_0000, 4'h1, 1'b0, 1'b1, -1);
        run_burst(8'd4, 16'h0020, 8'd2, 3'd3, 2'b01, 32'h4444_0000, 4'hF, 1'b0, 1'b1, -1);
        run_burst(8'd6, 16'hFFF8, 8'd3, 3'd2, 2'b10, 32'h5555_0000, 4'hA, 1'b0, 1'b1, -1);
        drain("drain_sizes");

        // RAM backpressure for 3 cycles mid-burst
        rdy_mode = 2;
        ram_wr_cmd_ready = 1'b1;
        base = cmd_count;
        fork
            run_burst(8'd7, 16'h0300, 8'd7, 3'd2, 2'b01, 32'h6666_0000, 4'hF, 1'b0, 1'b0, -1);
            begin
                repeat (5) @(posedge clk);
                #1;
                ram_wr_cmd_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                ram_wr_cmd_ready = 1'b1;
            end
        join
        drain("drain_backpressure");
        chk("backpressure_cmd_count", 64'(cmd_count - base), 64'd8);
        rdy_mode = 0;

        // Reset after 2 of 4 beats, then a clean burst
        run_burst(8'd8, 16'h0180, 8'd3, 3'd2, 2'b01, 32'h7777_0000, 4'hF, 1'b0, 1'b0, 2);
        drain("drain_before_reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_en", 64'(ram_wr_cmd_en), 64'd0);
        chk("post_rst_awready", 64'(s_axi_awready), 64'd0);
        chk("post_rst_wready", 64'(s_axi_wready), 64'd0);
        run_burst(8'd9, 16'h0200, 8'd3, 3'd2, 2'b01, 32'h8888_0000, 4'hF, 1'b0, 1'b0, -1);
        drain("drain_after_reset");

        // Randomized bursts with random RAM backpressure and W gaps
        rdy_mode = 1;
        for (int i = 0; i < 12; i++) begin
            run_burst(8'($urandom), 16'($urandom), 8'($urandom_range(0, 7)), 3'($urandom_range(0, 3)),
                      2'($urandom_range(0, 2)), 32'($urandom), 4'($urandom), 1'b1, 1'b0, -1);
        end
        drain("drain_random");
        rdy_mode = 0;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
